cordic_img_collector: RTL and testbench
=======================================

# cordic_img_collector

Downstream stage of the pipelined CORDIC rotator in the ant-sprite rotation path. It tracks which CORDIC output cycles carry real points by running an in_valid/in_last token shift register matched to the CORDIC latency. It converts each rotated fixed-point (x, y) into centred pixel coordinates and sets the matching bit in an internal 48×48 rotated-image bitmap. A registered row-read port serves the display logic.

## Interface
Parameters:
- IMG_DIM, 48: bitmap width/height in pixels.
- CENTER, 24: pixel offset added to the rotated integer coordinate (origin at sprite centre).
- COORD_W, 10: width of CORDIC xo/yo, signed two's complement.
- COORD_FRAC, 2: fraction bits in xo/yo.
- CORDIC_LAT, 19: CORDIC input-to-output latency in clk cycles.

Ports:
- clk  in  1  single clock, shared with the CORDIC.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins clear and then collect of a new frame.
- in_valid  in  1  qualifies the point presented to the CORDIC this cycle.
- in_last  in  1  marks the final point of the frame; meaningful only with in_valid.
- xo  in  COORD_W  CORDIC rotated x output.
- yo  in  COORD_W  CORDIC rotated y output.
- ready  out  1  high only in COLLECT; upstream may assert in_valid only when ready.
- busy  out  1  high in CLEAR or COLLECT.
- done  out  1  level; high in DONE until the next start.
- rd_row  in  6  bitmap row to read.
- rd_data  out  IMG_DIM  registered row contents; bit n = column n.
- drop_cnt  out  8  count of out-of-range points (see Configuration).

## Operation
- FSM states: IDLE, CLEAR, COLLECT, DONE. Reset state is IDLE.
- IDLE/DONE + start → CLEAR. The row counter zeroes one row per cycle, rows 0..IMG_DIM-1, which takes IMG_DIM cycles. The token shift register is flushed, and drop_cnt is zeroed.
- CLEAR: after row IMG_DIM-1 is written → COLLECT.
- COLLECT: the token (in_valid & ready, in_last) enters stage 0 of the CORDIC_LAT-deep shift register. in_valid outside COLLECT is ignored and no token is inserted.
- Tap: when the token leaves stage CORDIC_LAT-1, xo/yo are sampled on that same edge.
- Conversion: p = (v + 2^(COORD_FRAC-1)) >>> COORD_FRAC, giving round-half-up, arithmetic. Then px = p + CENTER, sized COORD_W+1 signed, no overflow.
- In range means 0 ≤ px,py ≤ IMG_DIM-1. In-range points set bitmap[py][px] (OR; duplicates harmless). Out-of-range points are discarded and drop_cnt increments.
- When the tap token has last=1, its write completes on that edge and the FSM → DONE.
- start in any state (including mid-CLEAR or COLLECT) restarts CLEAR at row 0; in-flight tokens are discarded.
- Read: rd_data ← bitmap[rd_row] on every edge, in any state. rd_row ≥ IMG_DIM yields 0.

## Timing
- areset: state IDLE, bitmap all 0, token register 0, rd_data 0, drop_cnt 0, ready/busy/done 0.
- start at edge S: CLEAR is active in cycle S+1. COLLECT (ready=1) begins IMG_DIM cycles later.
- Point accepted at edge A: bitmap bit is set at edge A+CORDIC_LAT. It is visible on rd_data at edge A+CORDIC_LAT+1 if rd_row already selects the row.
- Last point accepted at edge L: done=1 from edge L+CORDIC_LAT onward.
- Throughput: one point per cycle, no back-pressure inside COLLECT.
- drop_cnt saturates at 255.

## Configuration
- COLLECTOR_DROP_CNT_EN defined: 8-bit saturating out-of-range counter, cleared on start/areset.
- Not defined: no counter logic; drop_cnt tied to 0. Out-of-range points are still discarded.

## Structure
- Package cordic_img_pkg holds IMG_DIM, CENTER, CORDIC_LAT, COORD_W, COORD_FRAC, the FSM state enum, and the pixel coordinate type. The CORDIC feeder shares the same constants.
- One sub-module, cordic_valid_delay: parameterised-depth shift register of {valid, last} with synchronous flush and async reset.

## Test plan
- Centre: start, wait for ready, feed one point with in_last. xo=0, yo=0 → done at A+19, rd_row=24 → rd_data bit 24 set, all other rows 0.
- Rounding: xo=3 (0.75), yo=-2 (-0.5) → pixel (25, 24). xo=-88 (-22) → px=2.
- Range: xo=96 (px=48) → no bit set, drop_cnt=1 with macro and 0 without. xo=-96 (px=0) → bit 0 set.
- Burst: 6 consecutive points, last on the 6th → all 6 bits set, done exactly 19 cycles after the 6th acceptance, ready dropped.
- Restart: start again mid-COLLECT with 5 tokens in flight → bitmap fully cleared after 48 cycles, no stale tokens written, done stays 0.
- Reset: assert areset during COLLECT → all outputs 0 on the next cycle without a clock edge, state IDLE, rd_data 0 for every row.

Source files
------------

// File: rtl/cordic_img_pkg.sv
// Shared constants and types for the CORDIC sprite-rotation path (collector and feeder).
package cordic_img_pkg;

  localparam int IMG_DIM    = 48;
  localparam int CENTER     = 24;
  localparam int COORD_W    = 10;
  localparam int COORD_FRAC = 2;
  localparam int CORDIC_LAT = 19;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COLLECT,
    DONE
  } state_t;

  // Centred pixel coordinate: one bit wider than the CORDIC output so the offset never wraps.
  typedef logic signed [COORD_W:0] pix_t;

endpackage

// File: rtl/cordic_valid_delay.sv
// {valid, last} token shift register matched to the CORDIC pipeline depth.
module cordic_valid_delay #(
  parameter int DEPTH = 19
) (
  input  logic clk,
  input  logic areset,
  input  logic flush,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] last_sr;

  // NOTE: non-blocking assignments make every stage sample its predecessor's old value.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else if (flush) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
      last_sr  <= {last_sr[DEPTH-2:0], in_last};
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/cordic_img_collector.sv
// Collects rotated CORDIC points into a 48x48 bitmap with a registered row-read port.
// Optional macro COLLECTOR_DROP_CNT_EN enables the saturating out-of-range counter.
module cordic_img_collector
  import cordic_img_pkg::*;
#(
  parameter int IMG_DIM    = cordic_img_pkg::IMG_DIM,
  parameter int CENTER     = cordic_img_pkg::CENTER,
  parameter int COORD_W    = cordic_img_pkg::COORD_W,
  parameter int COORD_FRAC = cordic_img_pkg::COORD_FRAC,
  parameter int CORDIC_LAT = cordic_img_pkg::CORDIC_LAT
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [COORD_W-1:0] xo,
  input  logic [COORD_W-1:0] yo,
  output logic               ready,
  output logic               busy,
  output logic               done,
  input  logic [5:0]         rd_row,
  output logic [IMG_DIM-1:0] rd_data,
  output logic [7:0]         drop_cnt
);

  localparam int PW    = COORD_W + 1;
  localparam int ROW_W = $clog2(IMG_DIM);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_DIM - 1);

  state_t state, state_nxt;
  logic [ROW_W-1:0]   row_cnt;
  logic [IMG_DIM-1:0] bitmap [IMG_DIM];

  logic tap_valid, tap_last;
  logic signed [PW-1:0] sx, sy, px, py;
  logic in_range, tap_fire;

  assign ready = (state == COLLECT);
  assign busy  = (state == CLEAR) || (state == COLLECT);
  assign done  = (state == DONE);

  cordic_valid_delay #(.DEPTH(CORDIC_LAT)) u_delay (
    .clk      (clk),
    .areset   (areset),
    .flush    (start),
    .in_valid (in_valid & ready),
    .in_last  (in_valid & ready & in_last),
    .out_valid(tap_valid),
    .out_last (tap_last)
  );

  // Round half up, then shift the origin to the sprite centre.
  assign sx = $signed({xo[COORD_W-1], xo}) + $signed(PW'(2 ** (COORD_FRAC - 1)));
  assign sy = $signed({yo[COORD_W-1], yo}) + $signed(PW'(2 ** (COORD_FRAC - 1)));
  assign px = (sx >>> COORD_FRAC) + $signed(PW'(CENTER));
  assign py = (sy >>> COORD_FRAC) + $signed(PW'(CENTER));

  assign in_range = (px >= 0) && (px < $signed(PW'(IMG_DIM))) &&
                    (py >= 0) && (py < $signed(PW'(IMG_DIM)));
  assign tap_fire = (state == COLLECT) && !start && tap_valid;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: assigning state_nxt before the case keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = CLEAR;
    end else begin
      unique case (state)
        CLEAR:   if (row_cnt == LAST_ROW) state_nxt = COLLECT;
        COLLECT: if (tap_valid && tap_last) state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)              row_cnt <= '0;
    else if (start)          row_cnt <= '0;
    else if (state == CLEAR) row_cnt <= row_cnt + 1'b1;
  end

  // NOTE: the bitmap is reset explicitly because the display may read it before any frame is drawn.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int r = 0; r < IMG_DIM; r++) bitmap[r] <= '0;
    end else if (!start && state == CLEAR) begin
      bitmap[row_cnt] <= '0;
    end else if (tap_fire && in_range) begin
      bitmap[py[ROW_W-1:0]][px[ROW_W-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)                 rd_data <= '0;
    else if (rd_row <= LAST_ROW) rd_data <= bitmap[rd_row];
    else                        rd_data <= '0;
  end

`ifdef COLLECTOR_DROP_CNT_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset)                                       drop_cnt <= '0;
    else if (start)                                   drop_cnt <= '0;
    else if (tap_fire && !in_range && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cordic_img_collector.sv
// Directed self-checking bench for cordic_img_collector with hand-computed pixel positions.
module tb_cordic_img_collector;

  logic        clk;
  logic        areset;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [9:0]  xo;
  logic [9:0]  yo;
  logic        ready;
  logic        busy;
  logic        done;
  logic [5:0]  rd_row;
  logic [47:0] rd_data;
  logic [7:0]  drop_cnt;

`ifdef COLLECTOR_DROP_CNT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  int tests = 0;
  int fails = 0;

  logic signed [9:0] vec_x [8];
  logic signed [9:0] vec_y [8];
  logic [47:0]       exp_rows [48];

  cordic_img_collector dut (
    .clk     (clk),
    .areset  (areset),
    .start   (start),
    .in_valid(in_valid),
    .in_last (in_last),
    .xo      (xo),
    .yo      (yo),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .rd_row  (rd_row),
    .rd_data (rd_data),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'd48);
  endtask

  // Feed k points on consecutive cycles, then present each point's xo/yo on its tap cycle.
  task automatic feed_frame(input int k, input bit with_last);
    for (int i = 0; i < k; i++) begin
      in_valid = 1'b1;
      in_last  = with_last && (i == k - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (19 - k) tick();
    for (int i = 0; i < k; i++) begin
      xo = vec_x[i];
      yo = vec_y[i];
      if (with_last && i == k - 1) check("done_before_lat", 64'(done), 64'd0);
      tick();
    end
    if (with_last) begin
      check("done_at_lat", 64'(done), 64'd1);
      check("ready_after_done", 64'(ready), 64'd0);
    end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 48; r++) exp_rows[r] = '0;
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 48; r++) begin
      rd_row = 6'(r);
      tick();
      check($sformatf("%s_row%0d", tag, r), 64'(rd_data), 64'(exp_rows[r]));
    end
    rd_row = 6'd50;
    tick();
    check($sformatf("%s_row50", tag), 64'(rd_data), 64'd0);
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    xo = '0; yo = '0; rd_row = '0;
    #12;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Centre point
    do_start();
    check("clear_busy", 64'(busy), 64'd1);
    check("clear_ready", 64'(ready), 64'd0);
    wait_ready("clear_len1");
    vec_x[0] = 10'sd0; vec_y[0] = 10'sd0;
    feed_frame(1, 1'b1);
    clear_exp();
    exp_rows[24][24] = 1'b1;
    check_rows("centre");
    check("centre_drop", 64'(drop_cnt), 64'd0);

    // Burst of six: rounding, range edges, one drop
    do_start();
    wait_ready("clear_len2");
    vec_x[0] = 10'sd3;   vec_y[0] = -10'sd2;
    vec_x[1] = -10'sd88; vec_y[1] = 10'sd0;
    vec_x[2] = 10'sd96;  vec_y[2] = 10'sd0;
    vec_x[3] = -10'sd96; vec_y[3] = 10'sd0;
    vec_x[4] = 10'sd0;   vec_y[4] = 10'sd92;
    vec_x[5] = -10'sd3;  vec_y[5] = 10'sd5;
    feed_frame(6, 1'b1);
    check("burst_drop", 64'(drop_cnt), 64'(EXP_DROP));
    clear_exp();
    exp_rows[24][25] = 1'b1;
    exp_rows[24][2]  = 1'b1;
    exp_rows[24][0]  = 1'b1;
    exp_rows[47][24] = 1'b1;
    exp_rows[25][23] = 1'b1;
    check_rows("burst");

    // Restart mid-COLLECT with five tokens in flight
    do_start();
    wait_ready("clear_len3");
    xo = 10'sd0; yo = 10'sd0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    do_start();
    wait_ready("clear_len_restart");
    check("restart_done", 64'(done), 64'd0);
    check("restart_drop", 64'(drop_cnt), 64'd0);
    clear_exp();
    check_rows("restart");
    check("restart_done_late", 64'(done), 64'd0);

    // Asynchronous reset during COLLECT
    vec_x[0] = 10'sd0;  vec_y[0] = 10'sd0;
    vec_x[1] = 10'sd96; vec_y[1] = 10'sd0;
    feed_frame(2, 1'b0);
    check("pre_rst_ready", 64'(ready), 64'd1);
    rd_row = 6'd24;
    tick();
    check("pre_rst_row", 64'(rd_data), 64'h0000_0100_0000);
    #2;
    areset = 1'b1;
    #1;
    check("async_ready", 64'(ready), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(done), 64'd0);
    check("async_rd_data", 64'(rd_data), 64'd0);
    check("async_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    tick();
    check("post_rst_ready", 64'(ready), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    clear_exp();
    check_rows("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
